// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - format select codes and pipeline state type for imm_gen_pipe
package imm_gen_pipe_pkg;

    localparam int IMM_SEL_W = 4;

    localparam logic [IMM_SEL_W-1:0] IMM_SEL_I    = 4'd0;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_S    = 4'd1;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_B    = 4'd2;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_U    = 4'd3;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_J    = 4'd4;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_Z    = 4'd5;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_CI   = 4'd6;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_CIW  = 4'd7;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_CLS  = 4'd8;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_CJ   = 4'd9;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_CB   = 4'd10;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_CLUI = 4'd11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - request and response handshake interfaces for imm_gen_pipe
interface imm_req_if #(
  parameter int TAG_W = 32
);
  import imm_gen_pipe_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic [IMM_SEL_W-1:0] in_sel;
  logic [TAG_W-1:0]     in_tag;

  modport master (output in_valid, in_inst, in_sel, in_tag, input in_ready);
  modport slave  (input in_valid, in_inst, in_sel, in_tag, output in_ready);
endinterface

interface imm_rsp_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (output out_valid, out_imm, out_tag, out_err, input out_ready);
  modport slave  (input out_valid, out_imm, out_tag, out_err, output out_ready);
endinterface

// File: rtl/imm_gen_pipe_imm_fmt.sv
// rtl/imm_gen_pipe_imm_fmt.sv - combinational immediate extraction; RVC formats built only with RVC_IMM_EN
module imm_fmt
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]          i_inst,
  input  logic [IMM_SEL_W-1:0] i_sel,
  output logic [XLEN-1:0]      o_imm,
  output logic                 o_err
);
  logic [31:0] w_imm32;
  logic [63:0] w_imm64;
  logic        w_unused_opcode;

  assign w_unused_opcode = &{1'b0, i_inst[6:0]};

  always_comb begin
    w_imm32 = '0;
    o_err   = 1'b0;
    case (i_sel)
      IMM_SEL_I: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_SEL_S: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_SEL_B: w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      IMM_SEL_U: w_imm32 = {i_inst[31:12], 12'b0};
      IMM_SEL_J: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      IMM_SEL_Z: w_imm32 = {27'b0, i_inst[19:15]};
`ifdef RVC_IMM_EN
      IMM_SEL_CI:   w_imm32 = {{26{i_inst[12]}}, i_inst[12], i_inst[6:2]};
      IMM_SEL_CIW:  w_imm32 = {22'b0, i_inst[10:7], i_inst[12:11], i_inst[5], i_inst[6], 2'b0};
      IMM_SEL_CLS:  w_imm32 = {25'b0, i_inst[5], i_inst[12:10], i_inst[6], 2'b0};
      IMM_SEL_CJ:   w_imm32 = {{20{i_inst[12]}}, i_inst[12], i_inst[8], i_inst[10:9], i_inst[6],
                               i_inst[7], i_inst[2], i_inst[11], i_inst[5:3], 1'b0};
      IMM_SEL_CB:   w_imm32 = {{23{i_inst[12]}}, i_inst[12], i_inst[6:5], i_inst[2],
                               i_inst[11:10], i_inst[4:3], 1'b0};
      IMM_SEL_CLUI: w_imm32 = {{14{i_inst[12]}}, i_inst[12], i_inst[6:2], 12'b0};
`endif
      default: o_err = 1'b1;
    endcase
  end

  // every format fits in 32 bits, so widening from bit 31 covers XLEN=64
  assign w_imm64 = {{32{w_imm32[31]}}, w_imm32};
  assign o_imm   = w_imm64[XLEN-1:0];
endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer (RVC_IMM_EN adds RVC formats)
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  imm_req_if.slave  s_req,
  imm_rsp_if.master m_rsp
);
  pipe_state_e      r_state;
  pipe_state_e      w_state_nxt;
  logic             r_in_ready;
  logic [XLEN-1:0]  r_main_imm,  r_skid_imm;
  logic [TAG_W-1:0] r_main_tag,  r_skid_tag;
  logic             r_main_err,  r_skid_err;
  logic [XLEN-1:0]  w_fmt_imm;
  logic             w_fmt_err;
  logic             w_accept, w_pop;
  logic             w_load_main, w_load_skid, w_skid_to_main;

  imm_fmt #(.XLEN(XLEN)) u_imm_fmt (
    .i_inst (s_req.in_inst),
    .i_sel  (s_req.in_sel),
    .o_imm  (w_fmt_imm),
    .o_err  (w_fmt_err)
  );

  assign w_accept = s_req.in_valid & r_in_ready;
  assign w_pop    = (r_state != ST_EMPTY) & m_rsp.out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          case ({w_accept, w_pop})
            2'b10: begin
              w_state_nxt = ST_FULL;
              w_load_skid = 1'b1;
            end
            2'b01: w_state_nxt = ST_EMPTY;
            2'b11: w_load_main = 1'b1;
            default: w_state_nxt = ST_ONE;
          endcase
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt    = ST_ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // ready is registered from the next state so no combinational path reaches in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_main_err <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_err <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_imm <= w_fmt_imm;
        r_main_tag <= s_req.in_tag;
        r_main_err <= w_fmt_err;
      end else if (w_skid_to_main) begin
        r_main_imm <= r_skid_imm;
        r_main_tag <= r_skid_tag;
        r_main_err <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_fmt_imm;
        r_skid_tag <= s_req.in_tag;
        r_skid_err <= w_fmt_err;
      end
    end
  end

  assign s_req.in_ready  = r_in_ready;
  assign m_rsp.out_valid = (r_state != ST_EMPTY);
  assign m_rsp.out_imm   = r_main_imm;
  assign m_rsp.out_tag   = r_main_tag;
  assign m_rsp.out_err   = r_main_err;
endmodule
